iram_resp: RTL
==============

# iram_resp

Instruction-memory responder: the target end of the fetch interface driven by the PC register's `iram_en`/`pc_o`. It accepts one fetch request at a time and reads a synchronous on-chip instruction RAM after a configurable number of wait states. It presents `inst_o`/`if_id_valid` to the IF/ID boundary and holds them until ID accepts. Flushes from branch/jump, exception entry or `mret` cancel any in-flight fetch.

## Interface
- `XLEN`, 32, data/address width.
- `DEPTH_LOG2`, 12, log2 of RAM depth in words.
- `WAIT_CYCLES`, 0, extra wait states per fetch (0..15).

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `iram_en`  in  1  fetch request.
- `addr`  in  XLEN  fetch byte address (PC).
- `flush`  in  1  cancel the current fetch (`bj_flag | jump2exp | ex_is_mret_inst`).
- `id_allowin`  in  1  ID stage can accept this cycle.
- `wr_en`  in  1  loader write strobe.
- `wr_addr`  in  DEPTH_LOG2  loader word address.
- `wr_data`  in  XLEN  loader write data.
- `if_id_valid`  out  1  `inst_o`/`pc_o` valid.
- `inst_o`  out  XLEN  fetched instruction.
- `pc_o`  out  XLEN  address of `inst_o`.
- `inst_misalign`  out  1  response carries a misaligned-fetch fault (see Configuration).

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE
  - A request is accepted when `iram_en` = 1 and `flush` = 0.
  - On acceptance, `addr` is latched into `pc_o`.
  - Next state is WAIT if `WAIT_CYCLES` > 0, otherwise RESP.
  - The RAM read of word `addr[DEPTH_LOG2+1:2]` is issued so that its data arrives on entry to RESP.
- WAIT
  - A 4-bit counter loads `WAIT_CYCLES-1` on entry and decrements each cycle.
  - At count 0 the state moves to RESP, and the RAM read is issued in that last WAIT cycle.
- RESP
  - `if_id_valid` = 1; `inst_o` is registered RAM data, held stable.
  - When `id_allowin` = 1 the handshake completes and the state returns to IDLE.
  - After a handshake, the next request is sampled in IDLE with the PC already advanced.
- `flush` = 1 in any state: next state is IDLE and `if_id_valid` drops the next cycle.
  - Any RAM data in flight is discarded.
  - A request is not accepted in a cycle where `flush` = 1.
- Flush and `id_allowin` in the same RESP cycle: flush wins, and the result is IDLE either way.
- Address bits above `DEPTH_LOG2+1` are ignored, so addresses wrap modulo the RAM size.
- Loader write port:
  - Writes have priority and are accepted in any state.
  - A read and a write to the same word in the same cycle returns the old data.
  - RAM contents are not reset.

## Timing
- Reset values: state IDLE, `if_id_valid` = 0, `inst_o` = 0, `pc_o` = 0, `inst_misalign` = 0, wait counter = 0.
- A request accepted at edge N gives `if_id_valid` = 1 from edge N+1+`WAIT_CYCLES`.
- Throughput is one instruction per 2+`WAIT_CYCLES` cycles with `id_allowin` held high.
- `if_id_valid` is registered; there is no combinational path from any input to any output.
- `rst_n` low mid-fetch: at the next edge, return to IDLE with reset values; the pending fetch is lost.

## Configuration
- `IRAM_MISALIGN_CHK_EN` defined:
  - An accepted request with `addr[1:0]` != 0 skips the RAM read.
  - It still takes the normal latency.
  - The response is presented as `inst_o` = `INST_NOP` (32'h0000_0013) with `inst_misalign` = 1, held with `if_id_valid`.
- `IRAM_MISALIGN_CHK_EN` undefined:
  - `addr[1:0]` is ignored and the word is read normally.
  - `inst_misalign` is tied to 0.

## Structure
- `defines.v` holds `XLEN`, `INST_BYTE_NUM`, `INST_NOP`, `TRUE`, `DFF_RST_ENABLE`, and the FSM state encodings `IRAM_IDLE`/`IRAM_WAIT`/`IRAM_RESP`.
- One sub-module, `iram_sp_ram`: a 1R1W synchronous RAM, `XLEN` × 2^`DEPTH_LOG2`, 1-cycle registered read, read-old-data on collision.
- FSM, wait counter, output registers and misalign logic live in `iram_resp`.

## Test plan
- Load word 0 = 32'h0000_0093, `WAIT_CYCLES` = 0, `iram_en` = 1 with `addr` = 0 at edge 0 -> `if_id_valid` = 1 at edge 1 with `inst_o` = 32'h0000_0093, `pc_o` = 0.
- `WAIT_CYCLES` = 3, request `addr` = 32'h8 -> valid at edge 4; hold `id_allowin` = 0 for 5 cycles -> `inst_o` and `pc_o` stable; `id_allowin` = 1 -> IDLE the next cycle.
- `flush` = 1 in the second WAIT cycle -> `if_id_valid` never rises; a new request for `addr` = 32'h40 next cycle returns word 16.
- In RESP, `flush` = 1 and `id_allowin` = 1 together -> IDLE, `if_id_valid` = 0 the next cycle; a request in the flush cycle is ignored.
- `wr_en` to word 5 = 32'hDEAD_BEEF in the same cycle as a read of word 5 (old value 32'h1111_1111) -> returns 32'h1111_1111; the next fetch returns 32'hDEAD_BEEF.
- With `IRAM_MISALIGN_CHK_EN`: `addr` = 32'h6 -> `inst_o` = 32'h0000_0013, `inst_misalign` = 1. Without the macro: returns word 1, `inst_misalign` = 0. Assert `rst_n` = 0 mid-WAIT -> all outputs 0 the next edge.

Source files
------------

// File: rtl/iram_resp_pkg.sv
// rtl/iram_resp_pkg.sv - shared constants and FSM state encoding for the instruction-memory responder
package iram_resp_pkg;

    localparam int          IRAM_XLEN      = 32;
    localparam int          INST_BYTE_NUM  = 4;
    localparam logic [31:0] INST_NOP       = 32'h0000_0013;
    localparam logic        TRUE           = 1'b1;
    localparam logic        DFF_RST_ENABLE = 1'b0;

    typedef enum logic [1:0] {
        IRAM_IDLE = 2'd0,
        IRAM_WAIT = 2'd1,
        IRAM_RESP = 2'd2
    } iram_state_e;

endpackage

// File: rtl/iram_sp_ram.sv
// rtl/iram_sp_ram.sv - 1R1W synchronous instruction RAM, registered read, old data on collision
import iram_resp_pkg::*;

module iram_sp_ram #(
    parameter int XLEN       = IRAM_XLEN,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    output logic [XLEN-1:0]       rd_data
);

    logic [XLEN-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [XLEN-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset so the array itself maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (rst_n == DFF_RST_ENABLE) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/iram_resp.sv
// rtl/iram_resp.sv - fetch responder FSM over iram_sp_ram; optional IRAM_MISALIGN_CHK_EN fault path
import iram_resp_pkg::*;

module iram_resp #(
    parameter int XLEN        = IRAM_XLEN,
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iram_en,
    input  logic [XLEN-1:0]       addr,
    input  logic                  flush,
    input  logic                  id_allowin,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    output logic                  if_id_valid,
    output logic [XLEN-1:0]       inst_o,
    output logic [XLEN-1:0]       pc_o,
    output logic                  inst_misalign
);

    localparam int         WSH       = $clog2(INST_BYTE_NUM);
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    iram_state_e           r_state;
    iram_state_e           w_state_next;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            w_wait_cnt_next;
    logic [XLEN-1:0]       r_pc;
    logic                  r_misalign;
    logic                  w_accept;
    logic                  w_rd_en;
    logic                  w_req_misalign;
    logic [DEPTH_LOG2-1:0] w_rd_addr;
    logic [XLEN-1:0]       w_ram_data;

`ifdef IRAM_MISALIGN_CHK_EN
    assign w_req_misalign = (addr[WSH-1:0] != '0);
`else
    assign w_req_misalign = 1'b0;
`endif

    // The read is issued from IDLE only without wait states; otherwise the latched PC drives it.
    assign w_rd_addr = (r_state == IRAM_IDLE) ? addr[DEPTH_LOG2+WSH-1:WSH]
                                              : r_pc[DEPTH_LOG2+WSH-1:WSH];

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_accept        = 1'b0;
        w_rd_en         = 1'b0;
        case (r_state)
            IRAM_IDLE: begin
                if (iram_en == TRUE && !flush) begin
                    w_accept        = 1'b1;
                    w_wait_cnt_next = WAIT_LOAD;
                    if (HAS_WAIT) begin
                        w_state_next = IRAM_WAIT;
                    end else begin
                        w_state_next = IRAM_RESP;
                        w_rd_en      = !w_req_misalign;
                    end
                end
            end
            IRAM_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_next = IRAM_RESP;
                    w_rd_en      = !r_misalign;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                end
            end
            IRAM_RESP: begin
                if (id_allowin) begin
                    w_state_next = IRAM_IDLE;
                end
            end
            default: w_state_next = IRAM_IDLE;
        endcase
        if (flush) begin
            w_state_next = IRAM_IDLE;
            w_rd_en      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n == DFF_RST_ENABLE) begin
            r_state    <= IRAM_IDLE;
            r_wait_cnt <= 4'd0;
            r_pc       <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_accept) begin
                r_pc       <= addr;
                r_misalign <= w_req_misalign;
            end
        end
    end

    iram_sp_ram #(
        .XLEN       (XLEN),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (w_ram_data)
    );

    assign if_id_valid   = (r_state == IRAM_RESP);
    assign inst_o        = r_misalign ? XLEN'(INST_NOP) : w_ram_data;
    assign pc_o          = r_pc;
    assign inst_misalign = r_misalign & if_id_valid;

endmodule
